// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_arb_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2**DEF_ADDR_WIDTH;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: the first valid bit at or after pointer
// (wrapping modulo N) wins; grant is one-hot on the winner.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] win
);

  // Walk from the farthest candidate back to the pointer so the nearest
  // valid requester is the last (and therefore winning) assignment.
  always_comb begin
    grant = '0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(pointer) + k) % N;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with a zero-scrub sequencer on the shared
// register-file write port. Optional macro: RF_X0_WRITE_FILTER_EN.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_start,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rg_wrt_en,
  output logic [ADDR_WIDTH-1:0]            rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]            rg_wrt_data,
  output logic                             busy,
  output logic                             clr_done
);

  localparam int                    PTR_W     = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(NUM_REQ - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [PTR_W-1:0]        ptr, win;
  logic [NUM_REQ-1:0]      grant;
  logic                    vld_p0;
  logic                    wr_p0;
  logic [ADDR_WIDTH-1:0]   dest_p0;
  logic [DATA_WIDTH-1:0]   data_p0;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .valid   (req_valid),
    .pointer (ptr),
    .grant   (grant),
    .win     (win)
  );

  // Stage p0: combinational grant and operand select
  assign vld_p0    = (state == RUN) && !clr_start && (|req_valid);
  assign req_ready = vld_p0 ? grant : '0;
  assign dest_p0   = req_dest[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign data_p0   = req_data[win*DATA_WIDTH +: DATA_WIDTH];
  assign busy      = (state == CLEAR);

`ifdef RF_X0_WRITE_FILTER_EN
  assign wr_p0 = (dest_p0 != '0);
`else
  assign wr_p0 = 1'b1;
`endif

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (cnt == LAST_ADDR) state_n = RUN;
      RUN:     if (clr_start)        state_n = CLEAR;
      default: state_n = CLEAR;
    endcase
  end

  // Stage p1: registered write port, stable for the register file's negedge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      cnt         <= '0;
      ptr         <= '0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
      clr_done    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        CLEAR: begin
          rg_wrt_en   <= 1'b1;
          rg_wrt_dest <= cnt;
          rg_wrt_data <= '0;
          clr_done    <= (cnt == LAST_ADDR);
          cnt         <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
        end
        default: begin
          clr_done <= 1'b0;
          cnt      <= '0;
          if (vld_p0) begin
            rg_wrt_en   <= wr_p0;
            rg_wrt_dest <= dest_p0;
            rg_wrt_data <= data_p0;
            ptr         <= (win == LAST_PTR) ? '0 : win + 1'b1;
          end else begin
            rg_wrt_en <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus scoreboard,
// with hand-written scrub, clear-request, reset and x0 sequences.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr_start;
  logic [NR-1:0]      req_valid;
  logic [NR*AW-1:0]   req_dest;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               rg_wrt_en;
  logic [AW-1:0]      rg_wrt_dest;
  logic [DW-1:0]      rg_wrt_data;
  logic               busy;
  logic               clr_done;

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_start   (clr_start),
    .req_valid   (req_valid),
    .req_dest    (req_dest),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_data (rg_wrt_data),
    .busy        (busy),
    .clr_done    (clr_done)
  );

  always #5 clk = ~clk;

  // Register file written on the negedge, as the real array would be.
  logic [DW-1:0] rf [2**AW];
  always @(negedge clk) if (rst_n && rg_wrt_en) rf[rg_wrt_dest] <= rg_wrt_data;

  typedef struct {
    logic [NR-1:0] valid;
    int            win;
  } vec_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vt [16];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [AW-1:0] d, logic [DW-1:0] x);
    req_dest[i*AW +: AW] = d;
    req_data[i*DW +: DW] = x;
  endtask

  task automatic check_scrub_step(int k, logic [NR-1:0] ready_req);
    chk($sformatf("scrub%0d_en", k), 32'(rg_wrt_en), 32'd1);
    chk($sformatf("scrub%0d_dest", k), 32'(rg_wrt_dest), 32'(k));
    chk($sformatf("scrub%0d_data", k), rg_wrt_data, 32'd0);
    chk($sformatf("scrub%0d_done", k), 32'(clr_done), 32'(k == 31));
    chk($sformatf("scrub%0d_ready", k), 32'(req_ready), 32'(ready_req));
    if (k < 31) chk($sformatf("scrub%0d_busy", k), 32'(busy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] last_dest;
    logic [DW-1:0] last_data;
    logic [AW-1:0] d   [NR];
    logic [DW-1:0] x   [NR];
    exp_t          e;

    // Round-robin expectations, pointer 0 at the start of RUN.
    vt[0]  = '{3'b111, 0};  vt[1]  = '{3'b111, 1};  vt[2]  = '{3'b111, 2};
    vt[3]  = '{3'b111, 0};  vt[4]  = '{3'b111, 1};  vt[5]  = '{3'b111, 2};
    vt[6]  = '{3'b000, -1}; vt[7]  = '{3'b110, 1};  vt[8]  = '{3'b011, 0};
    vt[9]  = '{3'b101, 2};  vt[10] = '{3'b100, 2};  vt[11] = '{3'b100, 2};
    vt[12] = '{3'b001, 0};  vt[13] = '{3'b001, 0};  vt[14] = '{3'b010, 1};
    vt[15] = '{3'b000, -1};

    rst_n = 1'b0; clr_start = 1'b0; req_valid = 3'b111;
    req_dest = '0; req_data = '0;
    tick(); tick();
    chk("rst_en", 32'(rg_wrt_en), 32'd0);
    chk("rst_dest", 32'(rg_wrt_dest), 32'd0);
    chk("rst_data", rg_wrt_data, 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Full scrub after reset release.
    req_valid = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_scrub_step(k, 3'b000);
    end
    tick();
    chk("post_scrub_busy", 32'(busy), 32'd0);
    chk("post_scrub_en", 32'(rg_wrt_en), 32'd0);
    chk("post_scrub_done", 32'(clr_done), 32'd0);
    chk("post_scrub_dest_hold", 32'(rg_wrt_dest), 32'd31);
    last_dest = 5'd31;
    last_data = '0;

    // Table-driven arbitration with a scoreboard of expected writes.
    for (int v = 0; v < 16; v++) begin
      req_valid = vt[v].valid;
      for (int i = 0; i < NR; i++) begin
        d[i] = AW'((v * 3 + i) % 31 + 1);
        x[i] = 32'hC0DE_0000 + 32'(v * 16 + i);
        set_req(i, d[i], x[i]);
      end
      #1;
      if (vt[v].win >= 0) begin
        chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(1 << vt[v].win));
        last_dest = d[vt[v].win];
        last_data = x[vt[v].win];
        sb.push_back('{1'b1, last_dest, last_data});
      end else begin
        chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'd0);
        sb.push_back('{1'b0, last_dest, last_data});
      end
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_en", v), 32'(rg_wrt_en), 32'(e.en));
      chk($sformatf("v%0d_dest", v), 32'(rg_wrt_dest), 32'(e.dest));
      chk($sformatf("v%0d_data", v), rg_wrt_data, e.data);
    end

    // Single requester, then read back through the negedge register file.
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    chk("single_en", 32'(rg_wrt_en), 32'd1);
    chk("single_dest", 32'(rg_wrt_dest), 32'd5);
    chk("single_data", rg_wrt_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("rf_read5", rf[5], 32'hDEADBEEF);

    // Clear request in RUN with requester 1 pending.
    @(posedge clk); #1;
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h1234_5678);
    clr_start = 1'b1;
    #1;
    chk("clr_ready", 32'(req_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    chk("clr_en", 32'(rg_wrt_en), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 32; k++) begin
      tick();
      check_scrub_step(k, (k == 31) ? 3'b010 : 3'b000);
    end
    tick();
    req_valid = '0;
    chk("clr_grant_en", 32'(rg_wrt_en), 32'd1);
    chk("clr_grant_dest", 32'(rg_wrt_dest), 32'd9);
    chk("clr_grant_data", rg_wrt_data, 32'h1234_5678);

    // Reset in the middle of a scrub.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      tick();
      chk($sformatf("mid%0d_dest", k), 32'(rg_wrt_dest), 32'(k));
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(rg_wrt_en), 32'd0);
    chk("midrst_dest", 32'(rg_wrt_dest), 32'd0);
    chk("midrst_data", rg_wrt_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_scrub_step(k, 3'b000);
    end

    // Destination x0 write.
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h1);
    #1;
    chk("x0_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
`ifdef RF_X0_WRITE_FILTER_EN
    chk("x0_en", 32'(rg_wrt_en), 32'd0);
`else
    chk("x0_en", 32'(rg_wrt_en), 32'd1);
    chk("x0_dest", 32'(rg_wrt_dest), 32'd0);
    chk("x0_data", rg_wrt_data, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
